// File: rtl/s2p_lane_scheduler.sv
// Round-robin scheduler sharing one serial-to-parallel shift register between
// NUM_LANES serial requesters; each word is tagged with the lane it came from.
module s2p_lane_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int WIDTH     = 8,
    localparam int LANE_W   = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] lane_req,
    input  logic [NUM_LANES-1:0] lane_din,
    output logic [NUM_LANES-1:0] lane_gnt,
    output logic [WIDTH-1:0]     dout_parallel,
    output logic [LANE_W-1:0]    dout_lane,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_abort
);

    // state | meaning
    // IDLE  | arbitrate among requesters, starting after the last granted lane
    // SHIFT | capture one bit per cycle from the granted lane (ptr)
    // OUT   | hold the assembled word until the consumer takes it

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

    state_t            state;
    logic [LANE_W-1:0] ptr;
    logic [LANE_W-1:0] pick;
    logic [LANE_W-1:0] idx;
    logic              found;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-2:0]  shreg;
    logic [WIDTH-1:0]  word;
    logic              bit_in;

    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            idx = LANE_W'((int'(ptr) + i) % NUM_LANES);
            if (!found && lane_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // ptr doubles as the select of the lane being deserialized
    assign bit_in = lane_din[ptr];
    assign word   = {shreg, bit_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= LANE_W'(NUM_LANES - 1);
            cnt           <= '0;
            shreg         <= '0;
            lane_gnt      <= '0;
            dout_parallel <= '0;
            dout_lane     <= '0;
            dout_valid    <= 1'b0;
            frame_abort   <= 1'b0;
        end else begin
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (found) begin
                        lane_gnt <= NUM_LANES'(1) << pick;
                        ptr      <= pick;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (lane_req[ptr]) begin
                        shreg <= word[WIDTH-2:0];
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            dout_parallel <= word;
                            dout_lane     <= ptr;
                            dout_valid    <= 1'b1;
                            lane_gnt      <= '0;
                            cnt           <= '0;
                            state         <= OUT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        // requester let go mid-frame: drop the partial word, lane keeps ptr and loses its turn
                        lane_gnt    <= '0;
                        frame_abort <= 1'b1;
                        cnt         <= '0;
                        state       <= IDLE;
                    end
                end
                OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s2p_lane_scheduler.sv
// Bench for s2p_lane_scheduler: lane requester models push expected words when a
// grant starts; a monitor pops and compares them at each output handshake.
module tb_s2p_lane_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] lane_req, lane_din, lane_gnt;
    logic [7:0] dout_parallel;
    logic [1:0] dout_lane;
    logic       dout_valid, dout_ready, frame_abort;

    logic [1:0] req2, din2, gnt2, dout2;
    logic [0:0] dout_lane2;
    logic       valid2, ready2, abort2;

    always #5 clk = ~clk;

    s2p_lane_scheduler #(.NUM_LANES(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .lane_req(lane_req), .lane_din(lane_din),
        .lane_gnt(lane_gnt), .dout_parallel(dout_parallel), .dout_lane(dout_lane),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .frame_abort(frame_abort)
    );

    s2p_lane_scheduler #(.NUM_LANES(2), .WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .lane_req(req2), .lane_din(din2),
        .lane_gnt(gnt2), .dout_parallel(dout2), .dout_lane(dout_lane2),
        .dout_valid(valid2), .dout_ready(ready2), .frame_abort(abort2)
    );

    logic [7:0] pat [4];
    int         bitcnt [4];
    int         abort_after [4];
    logic [1:0] pat2 [2];
    int         bc2 [2];

    logic [7:0] sb_data [$];
    logic [1:0] sb_lane [$];
    logic [1:0] exp_lane_q [$];
    logic [1:0] sb2_data [$];
    logic       sb2_lane [$];
    logic       exp_lane2_q [$];

    int cyc = 0;
    int last_gnt = -1, last_gnt2 = -1;
    int period = 0, period2 = 0;
    int n_checks = 0, n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_gnt"}, lane_gnt, 0);
        chk({pfx, "_valid"}, dout_valid, 0);
        chk({pfx, "_data"}, dout_parallel, 0);
        chk({pfx, "_lane"}, dout_lane, 0);
        chk({pfx, "_abort"}, frame_abort, 0);
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!dout_valid && n < max) begin
            tick();
            n++;
        end
        chk("valid_seen", dout_valid, 1);
    endtask

    // requester models drive bits on the falling edge; monitor samples handshakes there too
    always @(negedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (lane_gnt[l]) begin
                if (bitcnt[l] == abort_after[l]) begin
                    lane_req[l] = 1'b0;
                end else if (bitcnt[l] < 8) begin
                    if (bitcnt[l] == 0) begin
                        if (abort_after[l] >= 8) begin
                            sb_data.push_back(pat[l]);
                            sb_lane.push_back(2'(l));
                        end
                        if (period != 0) begin
                            if (last_gnt >= 0) chk("gnt_period", cyc - last_gnt, period);
                            last_gnt = cyc;
                        end
                    end
                    lane_din[l] = pat[l][7 - bitcnt[l]];
                    bitcnt[l]++;
                end
            end else begin
                bitcnt[l] = 0;
            end
        end
        for (int l = 0; l < 2; l++) begin
            if (gnt2[l]) begin
                if (bc2[l] == 0) begin
                    sb2_data.push_back(pat2[l]);
                    sb2_lane.push_back(1'(l));
                    if (period2 != 0) begin
                        if (last_gnt2 >= 0) chk("gnt_period2", cyc - last_gnt2, period2);
                        last_gnt2 = cyc;
                    end
                end
                if (bc2[l] < 2) din2[l] = pat2[l][1 - bc2[l]];
                bc2[l]++;
            end else begin
                bc2[l] = 0;
            end
        end
        if (dout_valid && dout_ready) begin
            if (sb_data.size() == 0) chk("unexpected_word", 1, 0);
            else begin
                chk("word_data", dout_parallel, sb_data.pop_front());
                chk("word_lane", dout_lane, sb_lane.pop_front());
            end
            if (exp_lane_q.size() != 0) chk("lane_order", dout_lane, exp_lane_q.pop_front());
        end
        if (valid2 && ready2) begin
            if (sb2_data.size() == 0) chk("unexpected_word2", 1, 0);
            else begin
                chk("word2_data", dout2, sb2_data.pop_front());
                chk("word2_lane", dout_lane2, sb2_lane.pop_front());
            end
            if (exp_lane2_q.size() != 0) chk("lane_order2", dout_lane2, exp_lane2_q.pop_front());
        end
    end

    initial begin
        int n, k;
        lane_req = '0; lane_din = '0; dout_ready = 1'b1;
        req2 = '0; din2 = '0; ready2 = 1'b1;
        for (int l = 0; l < 4; l++) begin
            abort_after[l] = 99;
            bitcnt[l] = 0;
            pat[l] = '0;
        end
        bc2[0] = 0; bc2[1] = 0;
        pat2[0] = 2'b10; pat2[1] = 2'b01;

        tick(); tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        // single lane 1 frame
        pat[1] = 8'hA5;
        lane_req = 4'b0010;
        tick();
        chk("t1_gnt", lane_gnt, 4'b0010);
        wait_valid(20, n);
        chk("t1_latency", n, 8);
        lane_req = '0;
        tick(); tick();

        // all lanes, back-to-back round robin
        rst = 1'b1; tick(); rst = 1'b0;
        pat[0] = 8'h10; pat[1] = 8'h21; pat[2] = 8'h32; pat[3] = 8'h43;
        exp_lane_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        last_gnt = -1; period = 10;
        lane_req = 4'hF;
        k = 0;
        while (exp_lane_q.size() != 0 && k < 80) begin
            tick();
            k++;
        end
        chk("t2_done", exp_lane_q.size(), 0);
        lane_req = '0; period = 0;
        tick(); tick();

        // consumer back-pressure
        dout_ready = 1'b0;
        lane_req = 4'b1010;
        tick();
        chk("t3_gnt", lane_gnt, 4'b0010);
        wait_valid(20, n);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", dout_valid, 1);
            chk("t3_hold_data", dout_parallel, 8'h21);
            chk("t3_hold_lane", dout_lane, 1);
            chk("t3_hold_gnt", lane_gnt, 0);
        end
        dout_ready = 1'b1;
        tick();
        chk("t3_gap_gnt", lane_gnt, 0);
        lane_req[1] = 1'b0;
        tick();
        chk("t3_next_gnt", lane_gnt, 4'b1000);
        wait_valid(20, n);
        lane_req = '0;
        tick(); tick();

        // lane 2 aborts after 3 bits, lane 3 waiting
        abort_after[2] = 3;
        lane_req = 4'b1100;
        tick();
        chk("t4_gnt", lane_gnt, 4'b0100);
        tick(); tick(); tick();
        chk("t4_abort_early", frame_abort, 0);
        tick();
        chk("t4_abort", frame_abort, 1);
        chk("t4_abort_gnt", lane_gnt, 0);
        chk("t4_abort_valid", dout_valid, 0);
        chk("t4_abort_data", dout_parallel, 8'h43);
        abort_after[2] = 99;
        lane_req[2] = 1'b1;
        tick();
        chk("t4_pulse", frame_abort, 0);
        chk("t4_skip", lane_gnt, 4'b1000);
        wait_valid(20, n);
        lane_req = '0;
        tick(); tick();

        // reset mid-shift and during OUT
        dout_ready = 1'b0;
        lane_req = 4'hF;
        tick();
        chk("t5_gnt0", lane_gnt, 4'b0001);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk_reset("t5_rst_shift");
        sb_data.delete(); sb_lane.delete();
        rst = 1'b0;
        tick();
        chk("t5_gnt_after_shift", lane_gnt, 4'b0001);
        wait_valid(20, n);
        tick();
        rst = 1'b1;
        tick();
        chk_reset("t5_rst_out");
        sb_data.delete(); sb_lane.delete();
        rst = 1'b0;
        tick();
        chk("t5_gnt_after_out", lane_gnt, 4'b0001);
        wait_valid(20, n);
        lane_req = '0;
        dout_ready = 1'b1;
        tick(); tick();

        // narrow build: two lanes alternating
        last_gnt2 = -1; period2 = 4;
        exp_lane2_q = {1'b0, 1'b1, 1'b0, 1'b1};
        req2 = 2'b11;
        tick();
        chk("t6_first_gnt", gnt2, 2'b01);
        k = 0;
        while (exp_lane2_q.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        chk("t6_done", exp_lane2_q.size(), 0);
        req2 = '0; period2 = 0;

        repeat (3) tick();
        chk("sb_empty", sb_data.size(), 0);
        chk("sb2_empty", sb2_data.size(), 0);
        chk("abort2_idle", abort2, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
